matrix_scanner: RTL and testbench
=================================

MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 Parameter CLKDIV, default 2: half-period of CCLK/RCLK/LE pulses, in clk12mhz cycles; legal range 1..255.
REQ-002 Parameter DWELL, default 256: per-row display cycles; multiple of 8; legal range 8..65536.
REQ-003 clk12mhz  input  1  the only clock; all logic on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  scan enable.
REQ-006 row_addr  output  4  framebuffer read address.
REQ-007 row_data  input  16  framebuffer row; valid one cycle after row_addr changes.
REQ-008 frame_start  output  1  one-cycle pulse when fetch of row 0 begins.
REQ-009 CSDI, CCLK, LE  output  1 each  column driver serial data, shift clock and latch.
REQ-010 RSDI, RCLK  output  1 each  row shift register data and clock.
REQ-011 OEB  output  1  display blank, active-high.

Function
REQ-012 States: IDLE, FETCH, SHIFT, LATCH, DISPLAY.
REQ-013 IDLE -> FETCH when enable=1; stays in IDLE otherwise.
REQ-014 FETCH: 2 cycles. Cycle 1 drives row_addr=row. Cycle 2 captures row_data into a 16-bit shift register.
REQ-015 frame_start is 1 in cycle 1 of FETCH when row=0; it is 0 at all other times.
REQ-016 SHIFT: 16 bits, MSB first; bit i drives CSDI=data[15-i] for 2*CLKDIV cycles.
REQ-017 In SHIFT, CCLK=0 for the first CLKDIV cycles of each bit and 1 for the second CLKDIV cycles; total 32*CLKDIV cycles.
REQ-018 LATCH: 2*CLKDIV cycles. First half: LE=1, RCLK=0. Second half: LE=0, RCLK=1.
REQ-019 RSDI=1 throughout LATCH when row=0; RSDI=0 otherwise.
REQ-020 DISPLAY lasts DWELL cycles, OEB=0 (unless modified by REQ-029).
REQ-021 At the end of DISPLAY, row increments modulo 16 (15 -> 0). Next state is FETCH if enable=1, else IDLE.
REQ-022 OEB=1 in IDLE, FETCH, SHIFT and LATCH.
REQ-023 CCLK, LE, RCLK and CSDI are 0 outside the states that drive them.
REQ-024 enable deasserted mid-row has no effect until the row completes DISPLAY; the row is never truncated.
REQ-025 Row period with defaults = 2 + 64 + 4 + 256 = 326 cycles; frame = 16 rows = 5216 cycles.
REQ-026 All outputs are registered; no combinational path exists from inputs to outputs.

Reset
REQ-027 reset_n=0 at a clock edge forces: state=IDLE, row=0, counters=0, OEB=1, and all other outputs 0 (row_addr=0). This applies in any state, including mid-SHIFT.
REQ-028 After reset_n returns to 1, the first frame starts at row 0 with frame_start asserted.

Configuration
REQ-029 Macro MATRIX_BRIGHTNESS_EN. When defined, a port brightness (input, 3 bits) is added, and DISPLAY is split into 8 slices of DWELL/8 cycles. OEB=0 in the first brightness+1 slices and OEB=1 in the rest. brightness is sampled on entry to DISPLAY.
REQ-030 Without MATRIX_BRIGHTNESS_EN, the brightness port is absent and OEB=0 for the full DWELL.

Verification
REQ-031 Reset: hold reset_n=0 for 3 cycles with enable=1 -> OEB=1, all other outputs 0, state IDLE.
REQ-032 Single row: row_data=16'h8001, defaults -> CSDI=1 for bit 0, 0 for bits 1-14, 1 for bit 15; 16 CCLK rising edges, each 4 cycles apart.
REQ-033 Latch/wrap: run 17 rows -> RSDI=1 during the LATCH of row 0 only; row_addr sequence 0..15,0; frame_start pulses 5216 cycles apart.
REQ-034 Enable drop: deassert enable mid-SHIFT of row 5 -> row 5 completes DISPLAY (256 cycles OEB=0), then IDLE with OEB=1 and row=6.
REQ-035 Reset mid-operation: assert reset_n=0 during the 8th bit of SHIFT -> next cycle all outputs are at reset values; restart fetches row 0.
REQ-036 With MATRIX_BRIGHTNESS_EN and brightness=3, DWELL=256 -> OEB=0 for exactly 128 cycles, then 1 for 128 cycles; brightness=7 -> OEB=0 for all 256 cycles.

Source files
------------

// File: rtl/matrix_scanner_if.sv
// matrix_scanner_if: framebuffer fetch and LED column/row driver signals of the matrix scanner
interface matrix_scanner_if;
  logic enable;
  logic [3:0] row_addr;
  logic [15:0] row_data;
  logic frame_start;
  logic CSDI;
  logic CCLK;
  logic LE;
  logic RSDI;
  logic RCLK;
  logic OEB;
  modport master (
    input enable, row_data,
    output row_addr, frame_start, CSDI, CCLK, LE, RSDI, RCLK, OEB
  );
  modport slave (
    output enable, row_data,
    input row_addr, frame_start, CSDI, CCLK, LE, RSDI, RCLK, OEB
  );
endinterface

// File: rtl/matrix_scanner.sv
// matrix_scanner: 16-row LED matrix scanner (fetch, shift, latch, display); MATRIX_BRIGHTNESS_EN adds 8-level OEB brightness
module matrix_scanner #(
  parameter int CLKDIV = 2,
  parameter int DWELL = 256
) (
  input logic clk12mhz,
  input logic reset_n,
`ifdef MATRIX_BRIGHTNESS_EN
  input logic [2:0] brightness,
`endif
  matrix_scanner_if.master bus
);
  localparam int CW = 17;
  localparam logic [CW-1:0] HALF = CW'(CLKDIV);
  localparam logic [CW-1:0] BIT_END = CW'(2 * CLKDIV - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, LATCH, DISPLAY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, on_lim;
  logic [3:0] bit_q, bit_d, row_q, row_d, row_addr_q, row_addr_d;
  logic [15:0] sr_q, sr_d;
  logic frame_start_q, frame_start_d, csdi_q, csdi_d, cclk_q, cclk_d;
  logic le_q, le_d, rsdi_q, rsdi_d, rclk_q, rclk_d, oeb_q, oeb_d;
`ifdef MATRIX_BRIGHTNESS_EN
  logic [2:0] bright_q, bright_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    row_d = row_q;
    sr_d = sr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = bus.enable ? FETCH : IDLE;
      end
      FETCH: if (cnt_q == CW'(1)) begin
        sr_d = bus.row_data;
        cnt_d = '0;
        bit_d = '0;
        state_d = SHIFT;
      end
      SHIFT: if (cnt_q == BIT_END) begin
        cnt_d = '0;
        sr_d = {sr_q[14:0], 1'b0};
        bit_d = bit_q + 4'd1;
        state_d = (bit_q == 4'd15) ? LATCH : SHIFT;
      end
      LATCH: if (cnt_q == BIT_END) begin
        cnt_d = '0;
        state_d = DISPLAY;
      end
      DISPLAY: if (cnt_q == DWELL_END) begin
        cnt_d = '0;
        row_d = row_q + 4'd1;
        state_d = bus.enable ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are computed from next-state values so the registered copies line up with the state they belong to.
  always_comb begin
`ifdef MATRIX_BRIGHTNESS_EN
    bright_d = (state_d == DISPLAY && state_q != DISPLAY) ? brightness : bright_q;
    on_lim = (CW'(bright_d) + CW'(1)) * CW'(DWELL / 8);
`else
    on_lim = CW'(DWELL);
`endif
    row_addr_d = (state_d == FETCH && cnt_d == '0) ? row_d : row_addr_q;
    frame_start_d = state_d == FETCH && cnt_d == '0 && row_d == 4'd0;
    csdi_d = state_d == SHIFT && sr_d[15];
    cclk_d = state_d == SHIFT && cnt_d >= HALF;
    le_d = state_d == LATCH && cnt_d < HALF;
    rclk_d = state_d == LATCH && cnt_d >= HALF;
    rsdi_d = state_d == LATCH && row_d == 4'd0;
    oeb_d = !(state_d == DISPLAY && cnt_d < on_lim);
  end
  always_ff @(posedge clk12mhz) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      row_q <= '0;
      sr_q <= '0;
      row_addr_q <= '0;
      frame_start_q <= 1'b0;
      csdi_q <= 1'b0;
      cclk_q <= 1'b0;
      le_q <= 1'b0;
      rsdi_q <= 1'b0;
      rclk_q <= 1'b0;
      oeb_q <= 1'b1;
`ifdef MATRIX_BRIGHTNESS_EN
      bright_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      row_q <= row_d;
      sr_q <= sr_d;
      row_addr_q <= row_addr_d;
      frame_start_q <= frame_start_d;
      csdi_q <= csdi_d;
      cclk_q <= cclk_d;
      le_q <= le_d;
      rsdi_q <= rsdi_d;
      rclk_q <= rclk_d;
      oeb_q <= oeb_d;
`ifdef MATRIX_BRIGHTNESS_EN
      bright_q <= bright_d;
`endif
    end
  end
  assign bus.row_addr = row_addr_q;
  assign bus.frame_start = frame_start_q;
  assign bus.CSDI = csdi_q;
  assign bus.CCLK = cclk_q;
  assign bus.LE = le_q;
  assign bus.RSDI = rsdi_q;
  assign bus.RCLK = rclk_q;
  assign bus.OEB = oeb_q;
endmodule

// File: tb/tb_matrix_scanner.sv
// tb_matrix_scanner: row-timeline model of the scanner checked every cycle, plus directed literal checks
module tb_matrix_scanner;
  localparam int CLKDIV = 2;
  localparam int DWELL = 256;
  localparam int LT0 = 2 + 32 * CLKDIV;
  localparam int DP0 = LT0 + 2 * CLKDIV;
  localparam int ROWLEN = DP0 + DWELL;
  logic clk12mhz = 1'b0;
  logic reset_n = 1'b0;
`ifdef MATRIX_BRIGHTNESS_EN
  logic [2:0] brightness = 3'd7;
  logic [2:0] m_br = 3'd0;
`endif
  matrix_scanner_if bus();
  matrix_scanner #(.CLKDIV(CLKDIV), .DWELL(DWELL)) dut (
    .clk12mhz(clk12mhz),
    .reset_n(reset_n),
`ifdef MATRIX_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .bus(bus)
  );
  always #5 clk12mhz = ~clk12mhz;
  logic [15:0] mem [16];
  always @(posedge clk12mhz) bus.row_data <= mem[bus.row_addr];
  // Model: a row is a 326-cycle timeline indexed by m_t; m_run is 0 while idle.
  logic m_ok = 1'b0;
  logic m_run = 1'b0;
  int m_t = 0;
  logic [3:0] m_row = 4'd0;
  logic [3:0] m_addr = 4'd0;
  always @(posedge clk12mhz) begin
    if (!reset_n) begin
      m_ok <= 1'b1;
      m_run <= 1'b0;
      m_t <= 0;
      m_row <= 4'd0;
      m_addr <= 4'd0;
    end else if (!m_run) begin
      if (bus.enable) begin
        m_run <= 1'b1;
        m_t <= 0;
        m_addr <= m_row;
      end
    end else if (m_t == ROWLEN - 1) begin
      m_row <= m_row + 4'd1;
      m_t <= 0;
      m_run <= bus.enable;
      if (bus.enable) m_addr <= m_row + 4'd1;
    end else begin
      m_t <= m_t + 1;
`ifdef MATRIX_BRIGHTNESS_EN
      if (m_t == DP0 - 1) m_br <= brightness;
`endif
    end
  end
  function automatic logic [10:0] exp_vec();
    logic fs, csdi, cclk, le, rsdi, rclk, oeb;
    int k, on_cycles;
    fs = 1'b0; csdi = 1'b0; cclk = 1'b0; le = 1'b0; rsdi = 1'b0; rclk = 1'b0; oeb = 1'b1;
    k = m_t - 2;
`ifdef MATRIX_BRIGHTNESS_EN
    on_cycles = (int'(m_br) + 1) * (DWELL / 8);
`else
    on_cycles = DWELL;
`endif
    if (m_run) begin
      fs = m_t == 0 && m_row == 4'd0;
      if (m_t >= 2 && m_t < LT0) begin
        csdi = mem[m_row][15 - k / (2 * CLKDIV)];
        cclk = (k % (2 * CLKDIV)) >= CLKDIV;
      end
      if (m_t >= LT0 && m_t < DP0) begin
        le = m_t < LT0 + CLKDIV;
        rclk = !le;
        rsdi = m_row == 4'd0;
      end
      if (m_t >= DP0) oeb = (m_t - DP0) >= on_cycles;
    end
    return {m_addr, fs, csdi, cclk, le, rsdi, rclk, oeb};
  endfunction
  function automatic logic [10:0] dvec();
    return {bus.row_addr, bus.frame_start, bus.CSDI, bus.CCLK, bus.LE, bus.RSDI, bus.RCLK, bus.OEB};
  endfunction
  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int n_rise, last_rise, bad_gap, n_oeb_low, n_rsdi;
  logic [15:0] bits;
  logic p_cclk = 1'b0;
  logic p_le = 1'b0;
  int fs_q[$];
  logic [3:0] addr_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic clr();
    n_rise = 0; last_rise = -1; bad_gap = 0; n_oeb_low = 0; bits = 16'h0;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk12mhz);
      cyc_n++;
      if (m_ok) begin
        n_chk++;
        if (dvec() !== exp_vec()) begin
          n_err++;
          $display("FAIL model_cmp cyc=%0d got=%b expected=%b", cyc_n, dvec(), exp_vec());
        end
      end
      if (bus.CCLK === 1'b1 && p_cclk === 1'b0) begin
        n_rise++;
        bits = {bits[14:0], bus.CSDI};
        if (last_rise >= 0 && cyc_n - last_rise != 4) bad_gap++;
        last_rise = cyc_n;
      end
      if (bus.LE === 1'b1 && p_le === 1'b0) addr_q.push_back(bus.row_addr);
      if (bus.frame_start === 1'b1) fs_q.push_back(cyc_n);
      if (bus.RSDI === 1'b1) n_rsdi++;
      if (bus.OEB === 1'b0) n_oeb_low++;
      p_cclk = bus.CCLK;
      p_le = bus.LE;
    end
  endtask
  initial begin
    for (int r = 0; r < 16; r++) mem[r] = 16'h1357 * 16'(r + 3) ^ 16'(r << 12);
    mem[0] = 16'h8001;
    bus.enable = 1'b1;
    clr();
    n_rsdi = 0;
    step(3);
    chk("reset_outputs", 32'(dvec()), 32'h001);
    reset_n = 1'b1;
    clr();
    n_rsdi = 0;
    fs_q.delete();
    addr_q.delete();
    step(ROWLEN);
    chk("row0_cclk_rises", n_rise, 16);
    chk("row0_csdi_bits", 32'(bits), 32'h8001);
    chk("row0_cclk_gap", bad_gap, 0);
    chk("row0_oeb_low", n_oeb_low, 256);
    step(16 * ROWLEN);
    chk("frame_start_count", fs_q.size(), 2);
    chk("frame_period", fs_q.size() >= 2 ? fs_q[1] - fs_q[0] : -1, 5216);
    chk("latch_count", addr_q.size(), 17);
    for (int i = 0; i < 17; i++) chk("row_addr_seq", i < addr_q.size() ? 32'(addr_q[i]) : 32'hffff, i % 16);
    chk("rsdi_cycles", n_rsdi, 8);
    step(4 * ROWLEN + 20);
    bus.enable = 1'b0;
    clr();
    step(ROWLEN - 20 + 10);
    chk("drop_oeb_low", n_oeb_low, 256);
    chk("drop_idle_outputs", 32'(dvec()), 32'h281);
    bus.enable = 1'b1;
    step(1);
    chk("resume_fetch_row6", 32'(dvec()), 32'h301);
    step(30);
    reset_n = 1'b0;
    step(1);
    chk("midshift_reset", 32'(dvec()), 32'h001);
    reset_n = 1'b1;
    step(1);
    chk("restart_row0", 32'(dvec()), 32'h041);
`ifdef MATRIX_BRIGHTNESS_EN
    brightness = 3'd3;
    clr();
    step(ROWLEN - 1);
    chk("bright3_oeb_low", n_oeb_low, 128);
    brightness = 3'd7;
    clr();
    step(ROWLEN);
    chk("bright7_oeb_low", n_oeb_low, 256);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
